// File: rtl/ff_pfram_arbiter_pkg.sv
// Shared definitions for the playfield RAM arbiter: default geometry,
// FSM state encoding and the worst-case video fetch latency.
package ff_pfram_arbiter_pkg;

  localparam int unsigned PF_AW           = 10;
  localparam int unsigned PF_DW           = 16;
  localparam int unsigned VID_LATENCY_MAX = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VID     = 3'd1,
    ST_CPU_RD  = 3'd2,
    ST_CPU_RDW = 3'd3,
    ST_CPU_WR  = 3'd4
  } pf_state_e;

endpackage

// File: rtl/ff_pfram_arbiter_if.sv
// Bus bundle between the arbiter, the CPU decode, the playfield scan and the pfram.
// master = surrounding logic (requests, RAM read data); slave = the arbiter.
interface ff_pfram_arbiter_if
  import ff_pfram_arbiter_pkg::*;
#(
  parameter int unsigned AW = PF_AW,
  parameter int unsigned DW = PF_DW
);

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_overrun;

  logic          cpu_sel;
  logic          cpu_rw;
  logic [1:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_dtack;

  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q;

  modport master (
    output vid_req, vid_addr, cpu_sel, cpu_rw, cpu_be, cpu_addr, cpu_wdata, ram_q,
    input  vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_dtack,
           ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  vid_req, vid_addr, cpu_sel, cpu_rw, cpu_be, cpu_addr, cpu_wdata, ram_q,
    output vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_dtack,
           ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/ff_pfram_arbiter_rd_capture.sv
// One-cycle delayed capture of synchronous RAM read data with a valid pulse.
// kill_i cancels the capture at the capture edge (result discarded).
module ff_pfram_arbiter_rd_capture
  import ff_pfram_arbiter_pkg::*;
#(
  parameter int unsigned DW = PF_DW
) (
  input  logic          clk12m,
  input  logic          reset_n,
  input  logic          en_i,
  input  logic          kill_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o,
  output logic          valid_o
);

  logic          en_q;
  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          fire;

  assign fire = en_q & ~kill_i;

  // Delay the enable to match RAM latency, then capture and pulse valid.
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      en_q    <= en_i;
      valid_q <= fire;
      if (fire) data_q <= d_i;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ff_pfram_arbiter.sv
// Playfield RAM arbiter: video fetch has fixed priority, CPU accesses
// use free slots and finish with a held DTACK handshake.
module ff_pfram_arbiter
  import ff_pfram_arbiter_pkg::*;
#(
  parameter int unsigned AW = PF_AW,
  parameter int unsigned DW = PF_DW
) (
  input logic               clk12m,
  input logic               reset_n,
  ff_pfram_arbiter_if.slave bus
);

  pf_state_e     state_q, state_d;
  logic          vid_pend_q, vid_pend_d;
  logic [AW-1:0] vid_addr_q, vid_addr_d;
  logic          vid_overrun_q, vid_overrun_d;
  logic          cpu_done_q, cpu_done_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]    ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  logic          vid_want;
  logic          cpu_done;
  logic          cpu_go;
  logic          cpu_rd_valid;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic [DW-1:0] cpu_rdata;

  // A read completes through the capture pulse, then cpu_done_q holds it;
  // OR-ing both makes done/dtack visible in the completion cycle itself.
  assign vid_want = bus.vid_req | vid_pend_q;
  assign cpu_done = cpu_done_q | cpu_rd_valid;
  assign cpu_go   = bus.cpu_sel & ~cpu_done;

  // FSM state register.
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: video wins any tie with the CPU.
  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (vid_want)    state_d = ST_VID;
        else if (cpu_go) state_d = bus.cpu_rw ? ST_CPU_RD : ST_CPU_WR;
        else             state_d = ST_IDLE;
      end
      ST_VID:     state_d = ST_IDLE;
      ST_CPU_RD:  state_d = ST_CPU_RDW;
      ST_CPU_RDW: state_d = vid_want ? ST_VID : ST_IDLE;
      ST_CPU_WR:  state_d = vid_want ? ST_VID : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: RAM controls registered alongside the state they belong to.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = '0;
    ram_wdata_d = ram_wdata_q;
    unique case (state_d)
      ST_VID:    ram_addr_d = bus.vid_req ? bus.vid_addr : vid_addr_q;
      ST_CPU_RD: ram_addr_d = bus.cpu_addr;
      ST_CPU_WR: begin
        ram_addr_d  = bus.cpu_addr;
        ram_we_d    = bus.cpu_be;
        ram_wdata_d = bus.cpu_wdata;
      end
      default: ;
    endcase
  end

  // Pending video request bookkeeping; the newest address always wins.
  always_comb begin
    vid_pend_d    = vid_pend_q;
    vid_addr_d    = vid_addr_q;
    vid_overrun_d = vid_overrun_q | (bus.vid_req & vid_pend_q);
    if (bus.vid_req) begin
      vid_pend_d = 1'b1;
      vid_addr_d = bus.vid_addr;
    end
    if (state_d == ST_VID) vid_pend_d = 1'b0;
  end

  // CPU completion: held while cpu_sel stays high, cleared on the edge after it falls.
  always_comb begin
    cpu_done_d = (cpu_done | (state_q == ST_CPU_WR)) & bus.cpu_sel;
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk12m or negedge reset_n) begin
    if (!reset_n) begin
      vid_pend_q    <= 1'b0;
      vid_addr_q    <= '0;
      vid_overrun_q <= 1'b0;
      cpu_done_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= '0;
      ram_wdata_q   <= '0;
    end else begin
      vid_pend_q    <= vid_pend_d;
      vid_addr_q    <= vid_addr_d;
      vid_overrun_q <= vid_overrun_d;
      cpu_done_q    <= cpu_done_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
    end
  end

  ff_pfram_arbiter_rd_capture #(.DW(DW)) u_vid_cap (
    .clk12m  (clk12m),
    .reset_n (reset_n),
    .en_i    (state_q == ST_VID),
    .kill_i  (1'b0),
    .d_i     (bus.ram_q),
    .q_o     (vid_data),
    .valid_o (vid_valid)
  );

  ff_pfram_arbiter_rd_capture #(.DW(DW)) u_cpu_cap (
    .clk12m  (clk12m),
    .reset_n (reset_n),
    .en_i    (state_q == ST_CPU_RD),
    .kill_i  (~bus.cpu_sel),
    .d_i     (bus.ram_q),
    .q_o     (cpu_rdata),
    .valid_o (cpu_rd_valid)
  );

  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.vid_data    = vid_data;
  assign bus.vid_valid   = vid_valid;
  assign bus.vid_overrun = vid_overrun_q;
  assign bus.cpu_rdata   = cpu_rdata;
  assign bus.cpu_dtack   = cpu_done;

endmodule
